// File: rtl/mbo_pintest_pkg.sv
// Shared definitions for the MBO pin tester: mode encodings, PRBS7 seed/taps and lock threshold.
package mbo_pintest_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_ECHO = 2'd1,
    MODE_PRBS = 2'd2,
    MODE_WALK = 2'd3
  } mode_e;

  localparam logic [6:0] PRBS_SEED    = 7'h7F;
  localparam int         PRBS_TAP_A   = 6;
  localparam int         PRBS_TAP_B   = 5;
  localparam int         LOCK_MATCHES = 16;
  localparam int         MATCH_CNT_W  = $clog2(LOCK_MATCHES);

  // x^7 + x^6 + 1, shifting towards the MSB; the MSB is the transmitted bit.
  function automatic logic [6:0] prbs7Next(input logic [6:0] state);
    return {state[5:0], state[PRBS_TAP_A] ^ state[PRBS_TAP_B]};
  endfunction

endpackage

// File: rtl/mbo_pintest_ch.sv
// One RS-485 channel of the pin tester: echo delay line, PRBS7 self-synchronising checker, lock and error count.
// Build option MBO_PINTEST_ERRCNT_EN enables the saturating error counter; without it lock is a pass/fail flag.
module mbo_pintest_ch
  import mbo_pintest_pkg::*;
#(
  parameter int DELAY = 8,
  parameter int ERR_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       mode_i,
  input  logic             mode_chg_i,
  input  logic             clr_err_i,
  input  logic             rxd_i,
  input  logic             prbs_bit_i,
  output logic             txd_o,
  output logic             de_o,
  output logic             lock_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  logic [DELAY-1:0]       dly_q, dly_d;
  logic                   armed_q, armed_d;
  logic [6:0]             hist_q, hist_d;
  logic [MATCH_CNT_W-1:0] matchCnt_q, matchCnt_d;
  logic                   lock_q, lock_d;
  logic                   txd_q, txd_d;
  logic                   de_q, de_d;
  logic                   tap;
  logic                   match;
`ifdef MBO_PINTEST_ERRCNT_EN
  logic [ERR_W-1:0]       errCnt_q, errCnt_d;
`endif

  assign tap   = dly_q[DELAY-1];
  assign match = (rxd_i == (hist_q[PRBS_TAP_A] ^ hist_q[PRBS_TAP_B]));

  // A mode change returns the channel to its reset state; clr_err is applied last so it beats any increment.
  always_comb begin
    dly_d      = dly_q;
    armed_d    = armed_q;
    hist_d     = hist_q;
    matchCnt_d = matchCnt_q;
    lock_d     = lock_q;
    txd_d      = txd_q;
    de_d       = de_q;
`ifdef MBO_PINTEST_ERRCNT_EN
    errCnt_d   = errCnt_q;
`endif
    if (mode_chg_i) begin
      dly_d      = '0;
      armed_d    = 1'b0;
      hist_d     = '0;
      matchCnt_d = '0;
      lock_d     = 1'b0;
      txd_d      = 1'b1;
      de_d       = 1'b0;
`ifdef MBO_PINTEST_ERRCNT_EN
      errCnt_d   = '0;
`endif
    end else begin
      case (mode_e'(mode_i))
        MODE_ECHO: begin
          dly_d = DELAY'({dly_q, rxd_i});
          if (tap) armed_d = 1'b1;
          if (tap || armed_q) begin
            de_d  = 1'b1;
            txd_d = tap;
          end
        end
        MODE_PRBS: begin
          txd_d  = prbs_bit_i;
          de_d   = 1'b1;
          hist_d = {hist_q[5:0], rxd_i};
          if (match) begin
            if (matchCnt_q == MATCH_CNT_W'(LOCK_MATCHES - 1)) lock_d = 1'b1;
            else matchCnt_d = matchCnt_q + 1'b1;
          end else begin
            matchCnt_d = '0;
`ifdef MBO_PINTEST_ERRCNT_EN
            if (lock_q && (errCnt_q != '1)) errCnt_d = errCnt_q + 1'b1;
`else
            lock_d = 1'b0;
`endif
          end
        end
        default: begin
          txd_d = 1'b1;
          de_d  = 1'b0;
        end
      endcase
      // Clearing also restarts the match run, so relock needs a fresh run of matches.
      if (clr_err_i) begin
        lock_d     = 1'b0;
        matchCnt_d = '0;
`ifdef MBO_PINTEST_ERRCNT_EN
        errCnt_d   = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      dly_q      <= '0;
      armed_q    <= 1'b0;
      hist_q     <= '0;
      matchCnt_q <= '0;
      lock_q     <= 1'b0;
      txd_q      <= 1'b1;
      de_q       <= 1'b0;
`ifdef MBO_PINTEST_ERRCNT_EN
      errCnt_q   <= '0;
`endif
    end else begin
      dly_q      <= dly_d;
      armed_q    <= armed_d;
      hist_q     <= hist_d;
      matchCnt_q <= matchCnt_d;
      lock_q     <= lock_d;
      txd_q      <= txd_d;
      de_q       <= de_d;
`ifdef MBO_PINTEST_ERRCNT_EN
      errCnt_q   <= errCnt_d;
`endif
    end
  end

  assign txd_o  = txd_q;
  assign de_o   = de_q;
  assign lock_o = lock_q;
`ifdef MBO_PINTEST_ERRCNT_EN
  assign err_cnt_o = errCnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: rtl/mbo_pin_tester.sv
// MBO board bring-up tester: N_CH RS-485 channels in echo / PRBS7 / pin-walk modes plus a free-running divided clock.
// Build option MBO_PINTEST_ERRCNT_EN enables per-channel saturating error counters on err_cnt_o.
module mbo_pin_tester
  import mbo_pintest_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int DELAY = 8,
  parameter int PAT_W = 22,
  parameter int DIV_W = 4,
  parameter int ERR_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            mode_i,
  input  logic                  clr_err_i,
  input  logic [N_CH-1:0]       rxd_i,
  output logic [N_CH-1:0]       txd_o,
  output logic [N_CH-1:0]       de_o,
  output logic [N_CH-1:0]       lock_o,
  output logic [N_CH*ERR_W-1:0] err_cnt_o,
  output logic [PAT_W-1:0]      pat_out_o,
  output logic                  clk_div_out_o
);

  mode_e            mode_q, mode_d;
  logic [6:0]       prbs_q, prbs_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             modeChg;
  logic             divWrap;

  assign modeChg = (mode_i != mode_q);
  assign divWrap = &div_q;

  // The divider free-runs through mode changes; generator and walk restart whenever the mode changes.
  always_comb begin
    mode_d = mode_e'(mode_i);
    div_d  = div_q + 1'b1;
    prbs_d = prbs_q;
    pat_d  = pat_q;
    if (modeChg) begin
      prbs_d = PRBS_SEED;
      pat_d  = '0;
    end else begin
      if (mode_q == MODE_PRBS) prbs_d = prbs7Next(prbs_q);
      if (mode_q == MODE_WALK) begin
        if (pat_q == '0) pat_d = PAT_W'(1);
        else if (divWrap) pat_d = PAT_W'({pat_q, pat_q[PAT_W-1]});
      end else begin
        pat_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mode_q <= MODE_IDLE;
      prbs_q <= PRBS_SEED;
      div_q  <= '0;
      pat_q  <= '0;
    end else begin
      mode_q <= mode_d;
      prbs_q <= prbs_d;
      div_q  <= div_d;
      pat_q  <= pat_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mbo_pintest_ch #(
      .DELAY(DELAY),
      .ERR_W(ERR_W)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .mode_i     (mode_q),
      .mode_chg_i (modeChg),
      .clr_err_i  (clr_err_i),
      .rxd_i      (rxd_i[i]),
      .prbs_bit_i (prbs_q[6]),
      .txd_o      (txd_o[i]),
      .de_o       (de_o[i]),
      .lock_o     (lock_o[i]),
      .err_cnt_o  (err_cnt_o[i*ERR_W +: ERR_W])
    );
  end

  assign pat_out_o     = pat_q;
  assign clk_div_out_o = div_q[DIV_W-1];

endmodule

// File: tb/tb_mbo_pin_tester.sv
// Self-checking bench for mbo_pin_tester: directed scenarios plus randomized traffic against a sequence-level model.
module tb_mbo_pin_tester;

  localparam int N_CH    = 3;
  localparam int DELAY   = 8;
  localparam int PAT_W   = 22;
  localparam int DIV_W   = 4;
  localparam int ERR_W   = 4;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
  localparam int DIV_MAX = (1 << DIV_W) - 1;
  localparam int LOCK_N  = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            mode;
  logic                  clrErr;
  logic [N_CH-1:0]       rxd;
  logic [N_CH-1:0]       txd, de, lock;
  logic [N_CH*ERR_W-1:0] errCnt;
  logic [PAT_W-1:0]      patOut;
  logic                  clkDiv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mbo_pin_tester #(
    .N_CH(N_CH), .DELAY(DELAY), .PAT_W(PAT_W), .DIV_W(DIV_W), .ERR_W(ERR_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .clr_err_i(clrErr), .rxd_i(rxd),
    .txd_o(txd), .de_o(de), .lock_o(lock), .err_cnt_o(errCnt),
    .pat_out_o(patOut), .clk_div_out_o(clkDiv)
  );

  // Model state: received bits and transmitted PRBS bits are kept as plain sequences per mode session.
  int              mMode;
  int              divCnt;
  int              walkPos;
  logic [N_CH-1:0] mTxd, mDe, mLock, mArmed;
  int              mErr[N_CH];
  int              mRun[N_CH];
  logic [N_CH-1:0] rxLog[$];
  bit              prbsOut[$];
  logic [N_CH-1:0] txdHist[$];

  task automatic clearChannels();
    mTxd   = '1;
    mDe    = '0;
    mLock  = '0;
    mArmed = '0;
    for (int c = 0; c < N_CH; c++) begin
      mErr[c] = 0;
      mRun[c] = 0;
    end
    rxLog.delete();
    prbsOut.delete();
    walkPos = -1;
  endtask

  task automatic modelStep(input logic rstV, input logic [1:0] modeV, input logic clrV,
                           input logic [N_CH-1:0] rxdV);
    bit wrap;
    bit tap;
    bit o;
    bit expBit;
    int n;
    if (!rstV) begin
      divCnt = 0;
      mMode  = 0;
      clearChannels();
    end else begin
      wrap   = (divCnt == DIV_MAX);
      divCnt = (divCnt + 1) % (DIV_MAX + 1);
      if (int'(modeV) != mMode) begin
        mMode = int'(modeV);
        clearChannels();
      end else begin
        n = rxLog.size();
        case (mMode)
          1: begin
            for (int c = 0; c < N_CH; c++) begin
              tap = (n >= DELAY) ? rxLog[n-DELAY][c] : 1'b0;
              if (tap) mArmed[c] = 1'b1;
              if (mArmed[c]) begin
                mDe[c]  = 1'b1;
                mTxd[c] = tap;
              end
            end
            rxLog.push_back(rxdV);
          end
          2: begin
            o = (n < 7) ? 1'b1 : (prbsOut[n-7] ^ prbsOut[n-6]);
            prbsOut.push_back(o);
            for (int c = 0; c < N_CH; c++) begin
              expBit = ((n >= 7) ? rxLog[n-7][c] : 1'b0) ^ ((n >= 6) ? rxLog[n-6][c] : 1'b0);
              mTxd[c] = o;
              mDe[c]  = 1'b1;
              if (rxdV[c] == expBit) begin
                mRun[c]++;
                if (mRun[c] >= LOCK_N) mLock[c] = 1'b1;
              end else begin
                mRun[c] = 0;
`ifdef MBO_PINTEST_ERRCNT_EN
                if (mLock[c] && mErr[c] < ERR_MAX) mErr[c]++;
`else
                mLock[c] = 1'b0;
`endif
              end
            end
            rxLog.push_back(rxdV);
          end
          3: walkPos = (walkPos < 0) ? 0 : (wrap ? (walkPos + 1) % PAT_W : walkPos);
          default: ;
        endcase
        if (clrV) begin
          mLock = '0;
          for (int c = 0; c < N_CH; c++) begin
            mErr[c] = 0;
            mRun[c] = 0;
          end
        end
      end
    end
    txdHist.push_back(mTxd);
    if (txdHist.size() > 4) void'(txdHist.pop_front());
  endtask

  task automatic checkVal(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkOutput();
    logic [N_CH*ERR_W-1:0] expErr;
    logic [PAT_W-1:0]      one;
    logic [PAT_W-1:0]      expPat;
    one = 1;
    for (int c = 0; c < N_CH; c++) expErr[c*ERR_W +: ERR_W] = ERR_W'(mErr[c]);
    expPat = (walkPos < 0) ? '0 : (one << walkPos);
    checkVal("txd", 64'(txd), 64'(mTxd));
    checkVal("de", 64'(de), 64'(mDe));
    checkVal("lock", 64'(lock), 64'(mLock));
    checkVal("err_cnt", 64'(errCnt), 64'(expErr));
    checkVal("pat_out", 64'(patOut), 64'(expPat));
    checkVal("clk_div_out", 64'(clkDiv), 64'((divCnt >> (DIV_W - 1)) & 1));
  endtask

  task automatic applyStimulus(input logic rstV, input logic [1:0] modeV, input logic clrV,
                               input logic [N_CH-1:0] rxdV);
    rst    = rstV;
    mode   = modeV;
    clrErr = clrV;
    rxd    = rxdV;
    @(posedge clk);
    modelStep(rstV, modeV, clrV, rxdV);
    @(negedge clk);
    checkOutput();
  endtask

  function automatic logic [N_CH-1:0] loopRx();
    if (txdHist.size() >= 2) return txdHist[txdHist.size()-2];
    return '1;
  endfunction

  task automatic runPrbs(input int cycles, input bit flipFirst, input bit clrFirst);
    logic [N_CH-1:0] rx;
    for (int i = 0; i < cycles; i++) begin
      rx = loopRx();
      if (i == 0 && flipFirst) rx[1] = ~rx[1];
      applyStimulus(1'b1, 2'd2, (i == 0) && clrFirst, rx);
    end
  endtask

  initial begin
    logic [3:0]       seq;
    logic [N_CH-1:0]  rx;
    logic [N_CH-1:0]  flipMask;
    logic [PAT_W-1:0] one;
    logic [1:0]       segMode;
    int               segLen;
    bit               segLoop;
    bit               found;

    clearChannels();
    divCnt = 0;
    mMode  = 0;
    one    = 1;

    // Reset and its literal state.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd0, 1'b0, '0);
    checkVal("reset_txd", 64'(txd), 64'(3'b111));
    checkVal("reset_de", 64'(de), 64'(0));
    checkVal("reset_pat", 64'(patOut), 64'(0));

    // Echo: 1,0,1,1 on channel 0 reappears DELAY edges later.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd1, 1'b0, '0);
    seq = 4'b1101;
    for (int k = 0; k < 16; k++) begin
      rx = '0;
      if (k < 4) rx[0] = seq[k];
      applyStimulus(1'b1, 2'd1, 1'b0, rx);
      if (k == 7) checkVal("echo_de_early", 64'(de[0]), 64'(0));
      if (k >= 8 && k <= 11) begin
        checkVal("echo_txd0", 64'(txd[0]), 64'(seq[k-8]));
        checkVal("echo_de0", 64'(de[0]), 64'(1));
      end
      if (k == 10) begin
        checkVal("echo_other_de", 64'(de[2:1]), 64'(0));
        checkVal("echo_other_txd", 64'(txd[2:1]), 64'(2'b11));
      end
    end

    // PRBS loopback through a two-cycle delay.
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, 2'd2, 1'b0, loopRx());
      if (k == 7) checkVal("prbs_bit6", 64'(txd), 64'(3'b111));
      if (k == 8) checkVal("prbs_bit7", 64'(txd), 64'(3'b000));
    end
    checkVal("prbs_lock", 64'(lock), 64'(3'b111));
    runPrbs(1000, 1'b0, 1'b0);
    checkVal("prbs_err_clean", 64'(errCnt), 64'(0));

    // Single flipped bit on channel 1.
    runPrbs(10, 1'b1, 1'b0);
`ifdef MBO_PINTEST_ERRCNT_EN
    checkVal("flip_err1", 64'(errCnt[ERR_W +: ERR_W]), 64'(3));
    checkVal("flip_lock1", 64'(lock[1]), 64'(1));
    for (int f = 0; f < 4; f++) runPrbs(10, 1'b1, 1'b0);
    checkVal("sat_err1", 64'(errCnt[ERR_W +: ERR_W]), 64'(15));
    runPrbs(10, 1'b1, 1'b0);
    checkVal("sat_hold_err1", 64'(errCnt[ERR_W +: ERR_W]), 64'(15));
    runPrbs(1, 1'b0, 1'b1);
    checkVal("clr_err1", 64'(errCnt[ERR_W +: ERR_W]), 64'(0));
`else
    checkVal("flip_lock1_drop", 64'(lock[1]), 64'(0));
`endif
    runPrbs(30, 1'b0, 1'b0);
    checkVal("relock", 64'(lock), 64'(3'b111));
    runPrbs(1, 1'b1, 1'b1);
    checkVal("clr_vs_inc_err1", 64'(errCnt[ERR_W +: ERR_W]), 64'(0));
    checkVal("clr_vs_inc_lock1", 64'(lock[1]), 64'(0));
    runPrbs(30, 1'b0, 1'b0);

    // Mid-PRBS switch to echo with clr_err and a mismatch on the same edge.
    rx = loopRx();
    rx[1] = ~rx[1];
    applyStimulus(1'b1, 2'd1, 1'b1, rx);
    checkVal("switch_lock", 64'(lock), 64'(0));
    checkVal("switch_err", 64'(errCnt), 64'(0));
    checkVal("switch_de", 64'(de), 64'(0));
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd1, 1'b0, '0);
    checkVal("echo_unarmed_de", 64'(de), 64'(0));

    // Pin walk: one bit per 16-clock step, wrapping after PAT_W steps.
    applyStimulus(1'b1, 2'd3, 1'b0, '0);
    applyStimulus(1'b1, 2'd3, 1'b0, '0);
    checkVal("walk_first", 64'(patOut), 64'(1));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b1, 2'd3, 1'b0, '0);
      if (patOut !== one) found = 1'b1;
    end
    checkVal("walk_step_seen", 64'(found), 64'(1));
    checkVal("walk_second", 64'(patOut), 64'(2));
    for (int k = 2; k <= PAT_W; k++) begin
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd3, 1'b0, '0);
      checkVal("walk_pos", 64'(patOut), 64'(one << (k % PAT_W)));
    end

    // Randomized traffic.
    for (int s = 0; s < 150; s++) begin
      segMode = 2'($urandom_range(0, 3));
      segLen  = $urandom_range(1, 40);
      segLoop = $urandom_range(0, 1) == 1;
      for (int i = 0; i < segLen; i++) begin
        rx = segLoop ? loopRx() : N_CH'($urandom);
        flipMask = '0;
        if ($urandom_range(0, 15) == 0) flipMask[$urandom_range(0, N_CH - 1)] = 1'b1;
        applyStimulus($urandom_range(0, 499) != 0, segMode, $urandom_range(0, 31) == 0, rx ^ flipMask);
      end
    end

    // Reset in the middle of locked PRBS traffic.
    runPrbs(40, 1'b0, 1'b0);
    runPrbs(10, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd2, 1'b0, loopRx());
    checkVal("midrst_txd", 64'(txd), 64'(3'b111));
    checkVal("midrst_de", 64'(de), 64'(0));
    checkVal("midrst_lock", 64'(lock), 64'(0));
    checkVal("midrst_err", 64'(errCnt), 64'(0));
    checkVal("midrst_pat", 64'(patOut), 64'(0));
    checkVal("midrst_clkdiv", 64'(clkDiv), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbo_pin_tester.md
# mbo_pin_tester

Parametrised board bring-up tester for the MBO FPGA. It drives and checks N_CH half-duplex RS-485 channels in one of three modes: delayed echo loopback, PRBS7 transmit-and-check, or walking-one pin test. It also produces a free-running divided clock for differential output buffers. It sits at top level between the transceiver and connector pins and the board I/O, and replaces the fixed three-channel test-pin logic.

## Interface
- N_CH, 3: number of RS-485 channels (1..8)
- DELAY, 8: echo delay-line depth in clocks (≥1)
- PAT_W, 22: width of the walking-one pin bus
- DIV_W, 4: walk step and clock divider exponent; step period is 2^DIV_W clocks
- ERR_W, 16: per-channel error counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- mode  in  2  0 idle, 1 echo, 2 PRBS, 3 pin walk
- clr_err  in  1  single-cycle pulse; clears lock and err_cnt
- rxd  in  N_CH  receiver data, one bit per channel
- txd  out  N_CH  transmitter data
- de  out  N_CH  driver enable
- lock  out  N_CH  PRBS checker locked
- err_cnt  out  N_CH*ERR_W  saturating error counts; channel i at [i*ERR_W +: ERR_W]
- pat_out  out  PAT_W  walking-one pin pattern
- clk_div_out  out  1  divided clock for OBUFDS

## Operation
- Reset (rst=0 at clk edge) sets: txd all 1, de all 0, lock 0, err_cnt 0, pat_out 0, clk_div_out 0, delay lines 0, PRBS register 7'h7F, div counter 0.
- mode is registered as mode_q. A cycle with mode ≠ mode_q is a mode-change cycle. On that cycle, all channel state, the PRBS register and pat_out take their reset values. The div counter and clk_div_out are not affected.
- Idle (0): txd=1, de=0, pat_out=0.
- Echo (1), per channel:
  - Shift register d[0]←rxd, d[k]←d[k-1]; tap = d[DELAY-1].
  - armed is set on the first cycle tap=1 and holds until reset or mode change.
  - On each edge where (tap | armed): de←1, txd←tap. The first received 1 is echoed, not lost.
- PRBS (2):
  - Shared generator p[6:0], polynomial x^7+x^6+1. Each edge: p←{p[5:0], p[6]^p[5]}.
  - All channels: txd←p[6], de←1.
  - Per channel, a self-synchronising checker keeps history h←{h[5:0], rxd}.
  - match = (rxd == h[6]^h[5]).
  - After 16 consecutive matches, lock←1. Lock holds until clr_err, mode change or reset.
  - While locked, each mismatch increments err_cnt, saturating at all-ones.
- Pin walk (3):
  - pat_out←1 on the first cycle in this mode.
  - Rotate left by one each time the div counter wraps.
  - txd=1, de=0.
- clr_err is honoured in every mode. It takes precedence over a same-cycle increment: the result is 0, not 1.
- clk_div_out = div counter MSB, toggling every 2^(DIV_W-1) clocks in all modes.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Echo latency: rxd sampled at edge t appears on txd after edge t+DELAY.
- PRBS: txd updates every clock. Lock asserts on the edge of the 16th consecutive match.
- A single flipped bit on a locked channel adds exactly 3 to err_cnt: the bit itself plus its two appearances as a feedback tap.
- A mode change takes effect on the edge it is first seen. New-mode outputs appear one edge later.
- Reset mid-operation wins over every other condition on the same edge.

## Configuration
- MBO_PINTEST_ERRCNT_EN defined: err_cnt counters are implemented as described.
- Not defined:
  - err_cnt is tied to 0.
  - lock still works, but drops to 0 on any mismatch.
  - Mismatch monitoring reduces to a pass/fail flag.

## Structure
- Package mbo_pintest_pkg holds:
  - mode encodings MODE_IDLE, MODE_ECHO, MODE_PRBS, MODE_WALK
  - PRBS_SEED (7'h7F) and tap positions
  - LOCK_MATCHES (16)
- Sub-module mbo_pintest_ch holds the per-channel delay line, echo arm, PRBS checker and error counter. It is instantiated N_CH times in a generate loop.
- The top level holds mode_q, the PRBS generator, the div counter and the walk register.

## Test plan
- Echo, DELAY=8: hold rxd[0]=0, then send 1,0,1,1 from edge t → de[0]=1 and txd[0]=1,0,1,1 after edges t+8..t+11; other channels stay de=0, txd=1.
- PRBS with txd looped to rxd through a 2-cycle delay → lock=all 1 within 25 clocks; err_cnt stays 0 over 1000 clocks.
- PRBS locked, one rxd[1] bit inverted → err_cnt[1]=3 and lock[1] stays 1; with MBO_PINTEST_ERRCNT_EN undefined, lock[1] drops to 0 instead.
- Pin walk, DIV_W=4, PAT_W=22 → pat_out=1, then 2, 4, … changing every 16 clocks; wraps from bit 21 back to 1 after 352 clocks.
- Mid-PRBS switch to echo, plus clr_err in the same cycle as a mismatch → lock=0, err_cnt=0 and de=0 until the first tap=1.
- err_cnt forced near saturation with ERR_W=4 → holds at 15, then clears to 0 on clr_err; rst=0 mid-operation → all reset values on the next edge.
